pipa_pulse_gen: RTL and testbench

//  Parametrised PIPA accelerometer simulator feeding the fpga_agc PIPA inputs. Replaces the

---
 rtl/agc_sim_pkg.sv | 16 +
 rtl/pipa_axis.sv | 95 +++++++++
 rtl/pipa_pulse_gen.sv | 103 ++++++++++
 tb/tb_pipa_pulse_gen.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_sim_pkg.sv
// Shared types and defaults for the AGC board-level simulators.
//   pipa_dir_t  : direction latched for one PIPA slot (none / plus / minus)
//   DefModeLen  : default slots per moding cycle
//   DefAccW     : default signed width of the per-axis pending-pulse accumulator
package agc_sim_pkg;

  typedef enum logic [1:0] {
    DirNone  = 2'd0,
    DirPlus  = 2'd1,
    DirMinus = 2'd2
  } pipa_dir_t;

  localparam int unsigned DefModeLen = 6;
  localparam int unsigned DefAccW    = 12;

endpackage

// File: rtl/pipa_axis.sv
// One simulated PIPA axis: pending-pulse accumulator with saturation, slot direction register
// and pipdat output gating.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   slot         : one-clk slot event (synchronised pipasw rising edge)
//   moding_en    : emit the nominal moding pattern when nothing is pending
//   moding_plus  : current moding phase lies in the plus half of the cycle
//   pipdat       : synchronised data gate
//   cmd_hit      : accepted command targets this axis
//   cmd_delta    : signed pulse count to add
//   pipa_p/m     : registered plus/minus pulse outputs
//   pending      : accumulator nonzero
//   sat          : combinational, high in the cycle an update clamps
module pipa_axis
  import agc_sim_pkg::*;
#(
  parameter int unsigned AccW   = DefAccW,
  parameter int unsigned DeltaW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slot,
  input  logic              moding_en,
  input  logic              moding_plus,
  input  logic              pipdat,
  input  logic              cmd_hit,
  input  logic [DeltaW-1:0] cmd_delta,
  output logic              pipa_p,
  output logic              pipa_m,
  output logic              pending,
  output logic              sat
);

  // Two guard bits hold acc - step + delta without overflow (DeltaW <= AccW).
  localparam int unsigned SumW = AccW + 2;
  localparam logic signed [SumW-1:0] AccMax = {3'b000, {(AccW - 1){1'b1}}};
  localparam logic signed [SumW-1:0] AccMin = {3'b111, {(AccW - 1){1'b0}}};

  logic signed [AccW-1:0] acc_q, acc_d;
  pipa_dir_t              dir_q, dir_d;
  logic                   p_q, m_q;
  logic signed [SumW-1:0] acc_ext, step, delta_ext, sum;

  always_comb begin
    acc_ext   = {{2{acc_q[AccW-1]}}, acc_q};
    delta_ext = cmd_hit ? {{(SumW - DeltaW){cmd_delta[DeltaW-1]}}, cmd_delta} : '0;
    step      = '0;
    dir_d     = dir_q;
    if (slot) begin
      // Pending injection takes the slot ahead of the moding pattern.
      if (acc_q > 0) begin
        dir_d = DirPlus;
        step  = SumW'(1);
      end else if (acc_q < 0) begin
        dir_d = DirMinus;
        step  = '1;
      end else if (moding_en) begin
        dir_d = moding_plus ? DirPlus : DirMinus;
      end else begin
        dir_d = DirNone;
      end
    end
    // Slot step and command merge into a single saturating update.
    sum = acc_ext - step + delta_ext;
    sat = 1'b0;
    if (sum > AccMax) begin
      acc_d = AccMax[AccW-1:0];
      sat   = 1'b1;
    end else if (sum < AccMin) begin
      acc_d = AccMin[AccW-1:0];
      sat   = 1'b1;
    end else begin
      acc_d = sum[AccW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dir_q <= DirNone;
      p_q   <= 1'b0;
      m_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      dir_q <= dir_d;
      p_q   <= pipdat && (dir_q == DirPlus);
      m_q   <= pipdat && (dir_q == DirMinus);
    end
  end

  assign pipa_p  = p_q;
  assign pipa_m  = m_q;
  assign pending = (acc_q != '0);

endmodule

// File: rtl/pipa_pulse_gen.sv
// PIPA accelerometer simulator driving the AGC PIPA inputs: N independent axes, configurable
// moding cycle, per-axis signed delta-V injection over a valid/ready command port.
// Ports:
//   clk, rst_n          : prop_clk domain clock, asynchronous active-low reset
//   pipasw, pipdat      : AGC sample strobe and data gate (asynchronous to clk)
//   moding_en           : emit nominal moding pattern on idle slots
//   cmd_valid/ready     : injection handshake
//   cmd_axis, cmd_delta : target axis and signed pulse count
//   pipa_p, pipa_m      : plus/minus pulse per axis (index 0 = X)
//   pending             : per-axis accumulator nonzero
//   sat_err             : sticky accumulate saturation flag, cleared only by reset
module pipa_pulse_gen
  import agc_sim_pkg::*;
#(
  parameter int unsigned N_AXES   = 3,
  parameter int unsigned MODE_LEN = DefModeLen,
  parameter int unsigned ACC_W    = DefAccW,
  parameter int unsigned DELTA_W  = 8,
  localparam int unsigned AxisW   = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pipasw,
  input  logic               pipdat,
  input  logic               moding_en,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [AxisW-1:0]   cmd_axis,
  input  logic [DELTA_W-1:0] cmd_delta,
  output logic [N_AXES-1:0]  pipa_p,
  output logic [N_AXES-1:0]  pipa_m,
  output logic [N_AXES-1:0]  pending,
  output logic               sat_err
);

  localparam int unsigned PhaseW = (MODE_LEN > 2) ? $clog2(MODE_LEN) : 1;

  logic [1:0]        sw_sync_q, pd_sync_q;
  logic              sw_prev_q;
  logic              slot;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic              moding_plus;
  logic              ready_q;
  logic              sat_err_q;
  logic [N_AXES-1:0] sat_vec;

  // Slot event is the rising edge of the synchronised strobe; pd_sync_q[1] shares its latency.
  assign slot        = sw_sync_q[1] & ~sw_prev_q;
  assign moding_plus = (phase_q < PhaseW'(MODE_LEN / 2));

  always_comb begin
    phase_d = phase_q;
    if (slot) begin
      phase_d = (phase_q == PhaseW'(MODE_LEN - 1)) ? '0 : phase_q + PhaseW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync_q <= '0;
      pd_sync_q <= '0;
      sw_prev_q <= 1'b0;
      phase_q   <= '0;
      ready_q   <= 1'b0;
      sat_err_q <= 1'b0;
    end else begin
      sw_sync_q <= {sw_sync_q[0], pipasw};
      pd_sync_q <= {pd_sync_q[0], pipdat};
      sw_prev_q <= sw_sync_q[1];
      phase_q   <= phase_d;
      ready_q   <= 1'b1;
      sat_err_q <= sat_err_q | (|sat_vec);
    end
  end

  assign cmd_ready = ready_q;
  assign sat_err   = sat_err_q;

  // Out-of-range axis indices match no instance, so such commands are dropped.
  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    logic hit;
    assign hit = cmd_valid && ready_q && (cmd_axis == AxisW'(i));

    pipa_axis #(
      .AccW  (ACC_W),
      .DeltaW(DELTA_W)
    ) u_axis (
      .clk        (clk),
      .rst_n      (rst_n),
      .slot       (slot),
      .moding_en  (moding_en),
      .moding_plus(moding_plus),
      .pipdat     (pd_sync_q[1]),
      .cmd_hit    (hit),
      .cmd_delta  (cmd_delta),
      .pipa_p     (pipa_p[i]),
      .pipa_m     (pipa_m[i]),
      .pending    (pending[i]),
      .sat        (sat_vec[i])
    );
  end

endmodule

// File: tb/tb_pipa_pulse_gen.sv
// Self-checking bench for pipa_pulse_gen: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the axis/phase rules.
module tb_pipa_pulse_gen;

  localparam int NA     = 3;
  localparam int ML     = 6;
  localparam int AccMax = 2047;
  localparam int AccMin = -2048;

  logic          clk = 1'b0;
  logic          rst_n, pipasw, pipdat, moding_en, cmd_valid, cmd_ready, sat_err;
  logic [1:0]    cmd_axis;
  logic [7:0]    cmd_delta;
  logic [NA-1:0] pipa_p, pipa_m, pending;

  always #5 clk = ~clk;

  pipa_pulse_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pipasw   (pipasw),
    .pipdat   (pipdat),
    .moding_en(moding_en),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_axis (cmd_axis),
    .cmd_delta(cmd_delta),
    .pipa_p   (pipa_p),
    .pipa_m   (pipa_m),
    .pending  (pending),
    .sat_err  (sat_err)
  );

  // ---------------- behavioural model ----------------
  // Raw inputs seen at clock edge E act on state at edge E+2 (slot) / outputs at E+2.
  int m_acc[NA];
  int m_dir[NA];  // 0 none, 1 plus, 2 minus
  int m_phase;
  bit m_p[NA], m_m[NA];
  bit m_sat, m_ready;
  bit sw_h[3], pd_h[3];

  always @(posedge clk) begin : model
    bit slot;
    int nv;
    if (!rst_n) begin
      for (int i = 0; i < NA; i++) begin
        m_acc[i] <= 0; m_dir[i] <= 0; m_p[i] <= 0; m_m[i] <= 0;
      end
      m_phase <= 0; m_sat <= 0; m_ready <= 0;
      for (int k = 0; k < 3; k++) begin
        sw_h[k] <= 0; pd_h[k] <= 0;
      end
    end else begin
      slot = sw_h[1] && !sw_h[2];
      for (int i = 0; i < NA; i++) begin
        m_p[i] <= pd_h[1] && (m_dir[i] == 1);
        m_m[i] <= pd_h[1] && (m_dir[i] == 2);
        nv = m_acc[i];
        if (slot) begin
          if (m_acc[i] > 0) begin
            m_dir[i] <= 1; nv = nv - 1;
          end else if (m_acc[i] < 0) begin
            m_dir[i] <= 2; nv = nv + 1;
          end else if (moding_en) begin
            m_dir[i] <= (m_phase < ML / 2) ? 1 : 2;
          end else begin
            m_dir[i] <= 0;
          end
        end
        if (cmd_valid && m_ready && int'(cmd_axis) == i) nv = nv + int'($signed(cmd_delta));
        if (nv > AccMax) begin
          nv = AccMax; m_sat <= 1;
        end else if (nv < AccMin) begin
          nv = AccMin; m_sat <= 1;
        end
        m_acc[i] <= nv;
      end
      if (slot) m_phase <= (m_phase + 1) % ML;
      m_ready <= 1;
      sw_h[0] <= pipasw; sw_h[1] <= sw_h[0]; sw_h[2] <= sw_h[1];
      pd_h[0] <= pipdat; pd_h[1] <= pd_h[0]; pd_h[2] <= pd_h[1];
    end
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_pass  = 0;
  int cnt_p[NA], cnt_m[NA], base_p[NA], base_m[NA];
  bit prev_p[NA], prev_m[NA];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic compare();
    logic [NA-1:0] ep, em, epn;
    if (!rst_n) begin
      chk("rst_pipa_p", int'(pipa_p), 0);
      chk("rst_pipa_m", int'(pipa_m), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_sat_err", int'(sat_err), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 0);
    end else begin
      for (int i = 0; i < NA; i++) begin
        ep[i] = m_p[i]; em[i] = m_m[i]; epn[i] = (m_acc[i] != 0);
      end
      chk("pipa_p", int'(pipa_p), int'(ep));
      chk("pipa_m", int'(pipa_m), int'(em));
      chk("pending", int'(pending), int'(epn));
      chk("sat_err", int'(sat_err), int'(m_sat));
      chk("cmd_ready", int'(cmd_ready), int'(m_ready));
    end
    chk("p_m_exclusive", int'(|(pipa_p & pipa_m)), 0);
    for (int i = 0; i < NA; i++) begin
      if (pipa_p[i] && !prev_p[i]) cnt_p[i]++;
      if (pipa_m[i] && !prev_m[i]) cnt_m[i]++;
      prev_p[i] = pipa_p[i];
      prev_m[i] = pipa_m[i];
    end
  endtask

  // Compare at the falling edge, then return just after the next rising edge to drive inputs.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < NA; i++) begin
      base_p[i] = cnt_p[i]; base_m[i] = cnt_m[i];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_cmd(input int axis, input int delta);
    cmd_valid = 1'b1; cmd_axis = 2'(axis); cmd_delta = 8'(delta);
    step();
    cmd_valid = 1'b0;
  endtask

  // One AGC slot; an optional command lands in the same clock as the slot update.
  task automatic slot(input bit with_cmd, input int axis, input int delta);
    pipasw = 1'b1;
    step(); step();
    if (with_cmd) begin
      cmd_valid = 1'b1; cmd_axis = 2'(axis); cmd_delta = 8'(delta);
    end
    pipdat = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    pipdat = 1'b0; pipasw = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    rst_n = 1'b0; pipasw = 1'b0; pipdat = 1'b0; moding_en = 1'b0;
    cmd_valid = 1'b0; cmd_axis = '0; cmd_delta = '0;
    step(); step(); step();
    chk("ready_in_reset", int'(cmd_ready), 0);
    rst_n = 1'b1;
    step(); step();
    chk("ready_after_release", int'(cmd_ready), 1);

    // Nominal moding: P,P,P,M,M,M twice per axis.
    moding_en = 1'b1;
    snap();
    repeat (12) slot(0, 0, 0);
    for (int i = 0; i < NA; i++) begin
      chk($sformatf("moding_plus_ax%0d", i), cnt_p[i] - base_p[i], 6);
      chk($sformatf("moding_minus_ax%0d", i), cnt_m[i] - base_m[i], 6);
    end

    // +5 on Y with moding off.
    moding_en = 1'b0;
    snap();
    send_cmd(1, 5);
    chk("inj_pending_y_set", int'(pending[1]), 1);
    repeat (6) slot(0, 0, 0);
    chk("inj_plus_y", cnt_p[1] - base_p[1], 5);
    chk("inj_minus_y", cnt_m[1] - base_m[1], 0);
    chk("inj_quiet_x", cnt_p[0] - base_p[0] + cnt_m[0] - base_m[0], 0);
    chk("inj_pending_y_clr", int'(pending[1]), 0);

    // -3 on X with moding on: phase keeps advancing, so moding resumes at M,M,M.
    moding_en = 1'b1;
    snap();
    send_cmd(0, -3);
    repeat (6) slot(0, 0, 0);
    chk("neg_minus_x", cnt_m[0] - base_m[0], 6);
    chk("neg_plus_x", cnt_p[0] - base_p[0], 0);
    chk("neg_plus_y", cnt_p[1] - base_p[1], 3);

    // Z acc=+1, then +4 in the same clock as the slot step: plus pulse, acc=4.
    moding_en = 1'b0;
    snap();
    send_cmd(2, 1);
    slot(1, 2, 4);
    chk("same_clk_plus_z", cnt_p[2] - base_p[2], 1);
    chk("same_clk_pending_z", int'(pending[2]), 1);
    repeat (4) slot(0, 0, 0);
    chk("same_clk_total_z", cnt_p[2] - base_p[2], 5);
    chk("same_clk_drained_z", int'(pending[2]), 0);

    // Saturation at +2047, verified by draining exactly 2047.
    do_reset();
    repeat (16) send_cmd(0, 127);
    send_cmd(0, 15);
    chk("sat_not_yet", int'(sat_err), 0);
    send_cmd(0, 1);
    step();
    chk("sat_set", int'(sat_err), 1);
    repeat (16) send_cmd(0, -127);
    send_cmd(0, -15);
    step();
    chk("sat_clamped_drain", int'(pending[0]), 0);
    chk("sat_sticky", int'(sat_err), 1);

    // Reset between the strobe edge and pipdat: no pulse, next slot starts at phase 0.
    do_reset();
    moding_en = 1'b1;
    snap();
    pipasw = 1'b1;
    step(); step();
    rst_n = 1'b0;
    pipdat = 1'b1;
    step(); step(); step();
    pipdat = 1'b0; pipasw = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("midrst_no_pulse", cnt_p[0] + cnt_m[0] - base_p[0] - base_m[0], 0);
    snap();
    slot(0, 0, 0);
    for (int i = 0; i < NA; i++) begin
      chk($sformatf("midrst_phase0_ax%0d", i), cnt_p[i] - base_p[i], 1);
    end

    // Randomized traffic, model-checked every cycle.
    repeat (3000) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 2) == 0) pipasw = ~pipasw;
      pipdat = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) moding_en = ~moding_en;
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_axis  = 2'($urandom_range(0, 3));
      cmd_delta = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6) - 3);
      step();
    end
    rst_n = 1'b1; cmd_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
